serializer_4b_5b: RTL
=====================

# serializer_4b_5b

Transmit-side serializer that sits directly downstream of `encoder_4b_5b`. It accepts 4-bit data nibbles over a valid/ready handshake and encodes each one through an instance of `encoder_4b_5b`. It shifts the resulting 5-bit symbols onto a single serial line, MSB first, one bit per clock. When no nibble is offered it fills the line with the IDLE symbol, and it can optionally apply NRZI line coding.

## Interface
- `IDLE_SYM`, default 5'b11111, symbol transmitted whenever no nibble is accepted at a symbol boundary.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `nibble_in`  input  4  data nibble; sampled only on a handshake.
- `nibble_valid`  input  1  upstream offers `nibble_in`.
- `nibble_ready`  output  1  block accepts a nibble this cycle.
- `tx_out`  output  1  registered serial line bit.
- `sym_start`  output  1  registered; high while `tx_out` carries bit 4 (first bit) of a symbol.
- `sym_idle`  output  1  registered; high while `tx_out` carries any bit of an IDLE fill symbol.

## Operation
- State:
  - 5-bit shift register `shreg`.
  - 3-bit bit counter `bitcnt`, range 0..4.
  - Idle flag for the symbol currently held in `shreg`.
- Current bit `cur = shreg[4]`.
- Every cycle:
  - `shreg <= shreg << 1`.
  - `bitcnt` increments.
  - `tx_out` updates from `cur`.
  - `sym_start <= (bitcnt == 0)`.
  - `sym_idle <=` idle flag.
- Symbol boundary is the cycle with `bitcnt == 4`:
  - `bitcnt` wraps to 0.
  - `shreg` reloads instead of shifting.
- Reload source:
  - `nibble_valid && nibble_ready`: the encoder output for `nibble_in`; idle flag cleared.
  - Otherwise: `IDLE_SYM`; idle flag set.
- `nibble_ready = (bitcnt == 4) && !rst`. This is combinational and high for exactly one cycle in five.
- A nibble held with valid high and ready low is not consumed. Upstream must keep it stable until the handshake.
- Encoding table, from `encoder_4b_5b` (hex in -> symbol):
  - 0->11110, 1->01001, 2->10100, 3->10101
  - 4->01010, 5->01011, 6->01110, 7->01111
  - 8->10010, 9->10011, A->10110, B->10111
  - C->11010, D->11011, E->11100, F->11101

## Timing
- Reset values:
  - `shreg = IDLE_SYM`, `bitcnt = 0`, idle flag = 1.
  - `tx_out = 0`, `sym_start = 0`, `sym_idle = 0`.
  - `nibble_ready = 0` while `rst` is high.
- After reset release:
  - The first line bit appears one cycle later, with `sym_start = 1` and `sym_idle = 1`.
  - The first handshake opportunity is the 5th cycle after release (`bitcnt == 4`).
- Latency: handshake in cycle T -> bit 4 of that symbol on `tx_out`, with `sym_start` high, in cycle T+2. Remaining bits follow in T+3..T+6.
- Throughput: one nibble per 5 cycles. Back-to-back handshakes produce gapless symbols.
- Reset asserted mid-symbol:
  - The partial symbol is discarded.
  - No handshake occurs in the reset cycle.
  - State returns to reset values on that edge.
- `nibble_valid` changing while ready is low has no effect.

## Configuration
- `SERIALIZER_NRZI_EN`:
  - Defined: `tx_out <= tx_out ^ cur`. A 1 toggles the line and a 0 holds it. The line level starts at 0 from reset.
  - Undefined: `tx_out <= cur`, plain NRZ.
- `sym_start`, `sym_idle` and all handshake timing are identical in both builds.

## Structure
- Shared package `line_code_pkg` holds:
  - `NIBBLE_W = 4`, `SYM_W = 5`, `SYM_IDLE = 5'b11111`.
  - The bit-counter width constant.
- Sub-module: instantiate the existing `encoder_4b_5b` (`.in(nibble_in)`, `.out(...)`) for the lookup. Do not duplicate the table.
- Serializer shift/count logic and NRZI stay in this module.

## Test plan
- Reset: hold `rst` for 3 cycles.
  - During reset: all outputs 0, `nibble_ready` 0.
  - After release, with valid low: `tx_out` shows 1,1,1,1,1 repeating, `sym_idle` = 1, `sym_start` every 5th cycle.
- Single nibble 0x0 at the first ready:
  - Two cycles later `tx_out` = 1,1,1,1,0 with `sym_idle` = 0.
  - IDLE resumes afterwards.
- Back-to-back with valid held high:
  - Nibbles 0x1, 0x2, 0xF produce contiguous 01001, 10100, 11101.
  - `nibble_ready` pulses exactly every 5 cycles.
- Valid asserted while ready is low (`bitcnt` = 1): nibble 0x9 is not accepted until the next boundary, then transmits as 10011.
- With `SERIALIZER_NRZI_EN` defined:
  - IDLE after reset gives `tx_out` = 1,0,1,0,1 (toggles every bit).
  - Nibble 0x0 (11110) from level 0 gives 1,0,1,0,0.
- Reset asserted at the 3rd bit of symbol 0x7: the next cycle shows reset values, and the post-release stream starts with a full IDLE symbol.

Source files
------------

// File: rtl/line_code_pkg.sv
// Shared constants for the 4b/5b line-code transmit path.
// Holds nibble/symbol widths, the IDLE symbol and the bit-counter width.
package line_code_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SYM_W    = 5;
    localparam int CNT_W    = 3;

    localparam logic [SYM_W-1:0] SYM_IDLE = 5'b11111;

    // Index of the last bit of a symbol; this is the symbol boundary.
    localparam logic [CNT_W-1:0] LAST_BIT = 3'd4;

endpackage

// File: rtl/encoder_4b_5b.sv
// 4b/5b encoder: combinational lookup of a data nibble to its 5-bit symbol.
// Ports: in  - 4-bit data nibble; out - 5-bit line symbol.
module encoder_4b_5b
    import line_code_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in,
    output logic [SYM_W-1:0]    out
);

    always_comb begin
        out = SYM_IDLE;
        case (in)
            4'h0: out = 5'b11110;
            4'h1: out = 5'b01001;
            4'h2: out = 5'b10100;
            4'h3: out = 5'b10101;
            4'h4: out = 5'b01010;
            4'h5: out = 5'b01011;
            4'h6: out = 5'b01110;
            4'h7: out = 5'b01111;
            4'h8: out = 5'b10010;
            4'h9: out = 5'b10011;
            4'hA: out = 5'b10110;
            4'hB: out = 5'b10111;
            4'hC: out = 5'b11010;
            4'hD: out = 5'b11011;
            4'hE: out = 5'b11100;
            4'hF: out = 5'b11101;
            default: out = SYM_IDLE;
        endcase
    end

endmodule

// File: rtl/serializer_4b_5b.sv
// 4b/5b transmit serializer: accepts nibbles over valid/ready, encodes them,
// and shifts 5-bit symbols MSB first onto tx_out, filling with IDLE_SYM.
// Optional macro SERIALIZER_NRZI_EN applies NRZI coding to tx_out.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   nibble_in     - data nibble, sampled on handshake
//   nibble_valid  - upstream offers nibble_in
//   nibble_ready  - combinational; high on the symbol-boundary cycle
//   tx_out        - registered serial line bit
//   sym_start     - registered; tx_out carries the first bit of a symbol
//   sym_idle      - registered; tx_out carries a bit of an IDLE fill symbol
module serializer_4b_5b
    import line_code_pkg::*;
#(
    parameter logic [SYM_W-1:0] IDLE_SYM = SYM_IDLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NIBBLE_W-1:0] nibble_in,
    input  logic                nibble_valid,
    output logic                nibble_ready,
    output logic                tx_out,
    output logic                sym_start,
    output logic                sym_idle
);

    logic [SYM_W-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic             idle_flag;
    logic [SYM_W-1:0] enc_sym;
    logic             cur;
    logic             boundary;
    logic             accept;

    encoder_4b_5b u_enc (
        .in  (nibble_in),
        .out (enc_sym)
    );

    assign cur          = shreg[SYM_W-1];
    assign boundary     = (bitcnt == LAST_BIT);
    assign nibble_ready = boundary && !rst;
    assign accept       = nibble_valid && nibble_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= IDLE_SYM;
            bitcnt    <= '0;
            idle_flag <= 1'b1;
            tx_out    <= 1'b0;
            sym_start <= 1'b0;
            sym_idle  <= 1'b0;
        end else begin
`ifdef SERIALIZER_NRZI_EN
            // A 1 toggles the line level, a 0 holds it.
            tx_out    <= tx_out ^ cur;
`else
            tx_out    <= cur;
`endif
            sym_start <= (bitcnt == '0);
            sym_idle  <= idle_flag;
            if (boundary) begin
                bitcnt <= '0;
                if (accept) begin
                    shreg     <= enc_sym;
                    idle_flag <= 1'b0;
                end else begin
                    shreg     <= IDLE_SYM;
                    idle_flag <= 1'b1;
                end
            end else begin
                bitcnt <= bitcnt + 3'd1;
                shreg  <= shreg << 1;
            end
        end
    end

endmodule
